// File: rtl/conv_mac_array.sv
// conv_mac_array: ARRAY_SIZE signed MAC lanes sharing a broadcast weight,
// windowed by an internal tap counter, with rescale/saturate/ReLU output.
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   i_valid           beat qualifier for i_pixel_bus / i_weight
//   i_pixel_bus       lane 0 in MSB slice, lane ARRAY_SIZE-1 in LSB slice
//   i_weight          weight broadcast to all lanes
//   i_relu            ReLU enable, taken from the last beat of a window
//   i_clear           abort partial window, drop in-flight beats
//   o_valid           one-cycle result strobe
//   o_pixel_bus       results, same packing as i_pixel_bus (held)
//   o_sat_bus         per-lane clip flag, MSB = lane 0 (held)
//   o_tap_cnt         beats accepted in the current window
module conv_mac_array #(
   parameter int ARRAY_SIZE  = 6,
   parameter int DATA_WIDTH  = 16,
   parameter int FRAC_BITS   = 8,
   parameter int ACC_WIDTH   = 40,
   parameter int KERNEL_TAPS = 9,
   localparam int TW = (KERNEL_TAPS > 1) ? $clog2(KERNEL_TAPS) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_valid,
   input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] i_pixel_bus,
   input  logic [DATA_WIDTH-1:0]            i_weight,
   input  logic                             i_relu,
   input  logic                             i_clear,
   output logic                             o_valid,
   output logic [ARRAY_SIZE*DATA_WIDTH-1:0] o_pixel_bus,
   output logic [ARRAY_SIZE-1:0]            o_sat_bus,
   output logic [TW-1:0]                    o_tap_cnt
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int BW = ARRAY_SIZE * DATA_WIDTH;
   localparam logic [TW-1:0] LAST_CNT = TW'(KERNEL_TAPS - 1);
   localparam logic signed [ACC_WIDTH-1:0] MAX_V =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] MIN_V =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic [TW-1:0]               r_tap_cnt;
   logic                        w_accept;
   logic                        w_first;
   logic                        w_last;
   logic                        w_flush;

   logic                        r_s1_valid;
   logic                        r_s1_first;
   logic                        r_s1_last;
   logic                        r_s1_relu;
   logic signed [PW-1:0]        r_s1_prod [ARRAY_SIZE];

   logic                        r_s2_last;
   logic                        r_s2_relu;
   logic signed [ACC_WIDTH-1:0] r_acc [ARRAY_SIZE];

   logic                        r_o_valid;
   logic [BW-1:0]               r_o_pix;
   logic [ARRAY_SIZE-1:0]       r_o_sat;
   logic [BW-1:0]               w_res_bus;
   logic [ARRAY_SIZE-1:0]       w_sat_bus;

   assign w_accept = i_valid & ~i_clear;
   // A zero count means either a fresh window or the beat after a wrap.
   assign w_first  = (r_tap_cnt == '0);
   assign w_last   = (r_tap_cnt == LAST_CNT);
   assign w_flush  = r_s2_last & ~i_clear;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tap_cnt <= '0;
      end else if (i_clear) begin
         r_tap_cnt <= '0;
      end else if (i_valid) begin
         r_tap_cnt <= w_last ? '0 : r_tap_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_first <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_relu  <= 1'b0;
         for (int k = 0; k < ARRAY_SIZE; k++) r_s1_prod[k] <= '0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_first <= w_first;
            r_s1_last  <= w_last;
            r_s1_relu  <= i_relu;
            for (int k = 0; k < ARRAY_SIZE; k++) begin
               r_s1_prod[k] <=
                  PW'($signed(i_pixel_bus[(ARRAY_SIZE-1-k)*DATA_WIDTH +: DATA_WIDTH]))
                  * PW'($signed(i_weight));
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_last <= 1'b0;
         r_s2_relu <= 1'b0;
         for (int k = 0; k < ARRAY_SIZE; k++) r_acc[k] <= '0;
      end else begin
         r_s2_last <= r_s1_valid & r_s1_last & ~i_clear;
         r_s2_relu <= r_s1_relu;
         if (r_s1_valid & ~i_clear) begin
            // A first beat reloads while the previous sum moves to S3.
            for (int k = 0; k < ARRAY_SIZE; k++) begin
               r_acc[k] <= r_s1_first ? ACC_WIDTH'(r_s1_prod[k])
                                      : r_acc[k] + ACC_WIDTH'(r_s1_prod[k]);
            end
         end
      end
   end

   for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
      logic signed [ACC_WIDTH-1:0] w_sh;
      logic [DATA_WIDTH-1:0]       w_clip;
      logic                        w_sat;
      always_comb begin
         w_sh   = r_acc[g] >>> FRAC_BITS;
         w_sat  = 1'b0;
         w_clip = w_sh[DATA_WIDTH-1:0];
         if (w_sh > MAX_V) begin
            w_clip = MAX_V[DATA_WIDTH-1:0];
            w_sat  = 1'b1;
         end else if (w_sh < MIN_V) begin
            w_clip = MIN_V[DATA_WIDTH-1:0];
            w_sat  = 1'b1;
         end
         // ReLU acts after clipping; the clip flag is left untouched.
         if (r_s2_relu && w_clip[DATA_WIDTH-1]) w_clip = '0;
      end
      assign w_res_bus[(ARRAY_SIZE-1-g)*DATA_WIDTH +: DATA_WIDTH] = w_clip;
      assign w_sat_bus[ARRAY_SIZE-1-g] = w_sat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_o_valid <= 1'b0;
         r_o_pix   <= '0;
         r_o_sat   <= '0;
      end else begin
         r_o_valid <= w_flush;
         if (w_flush) begin
            r_o_pix <= w_res_bus;
            r_o_sat <= w_sat_bus;
         end
      end
   end

   assign o_valid     = r_o_valid;
   assign o_pixel_bus = r_o_pix;
   assign o_sat_bus   = r_o_sat;
   assign o_tap_cnt   = r_tap_cnt;

endmodule

// File: doc/conv_mac_array.md
# conv_mac_array

Parametrised convolution MAC array: ARRAY_SIZE signed multiply-accumulate lanes share one broadcast weight and each take one pixel from a packed bus. An internal tap counter closes each window after KERNEL_TAPS valid beats. Each lane then emits a rescaled, saturated and optionally ReLU'd result with a one-cycle valid pulse. The block sits in the conv layer between the pixel cache/line-buffer and the pooling/writeback stage, and removes the external clear-delay alignment that earlier arrays required.

## Interface
- ARRAY_SIZE, 6: number of parallel lanes (≥1).
- DATA_WIDTH, 16: signed two's-complement pixel/weight/output width.
- FRAC_BITS, 8: fractional bits of the fixed-point format; rescale shift.
- ACC_WIDTH, 40: accumulator width (≥ 2*DATA_WIDTH + clog2(KERNEL_TAPS)).
- KERNEL_TAPS, 9: valid beats per window (e.g. 9 = 3x3, 25 = 5x5); ≥1.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  beat qualifier for i_pixel_bus/i_weight.
- i_pixel_bus  in  ARRAY_SIZE*DATA_WIDTH  lane 0 in the MSB slice, lane ARRAY_SIZE-1 in the LSB slice.
- i_weight  in  DATA_WIDTH  weight broadcast to all lanes.
- i_relu  in  1  ReLU enable; sampled on the last beat of each window.
- i_clear  in  1  abort the current partial window and discard in-flight beats.
- o_valid  out  1  one-cycle result strobe.
- o_pixel_bus  out  ARRAY_SIZE*DATA_WIDTH  results, same lane packing as the input.
- o_sat_bus  out  ARRAY_SIZE  per-lane saturation flag, bit ARRAY_SIZE-1-k = lane k (MSB = lane 0).
- o_tap_cnt  out  clog2(KERNEL_TAPS) (min 1)  beats accepted in the current window.

## Operation
- Tap counter: increments on each accepted beat (i_valid=1, i_clear=0). It wraps to 0 on the beat where the count equals KERNEL_TAPS-1; that beat is tagged last. The first beat after a wrap is tagged first.
- S1 (product): each lane registers pixel*weight (2*DATA_WIDTH, signed) with the valid/first/last tags and relu (captured on the last beat).
- S2 (accumulate): on a valid S1 beat, the accumulator loads the sign-extended product if the beat is tagged first, otherwise it adds the product. The last/relu tags are registered alongside.
- S3 (output): when S2 holds a last beat, each lane is loaded with the result and o_valid=1 for exactly one cycle.
  - Result = acc >>> FRAC_BITS (arithmetic shift, truncation toward −inf).
  - The result saturates to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1], and the lane's o_sat bit is set on clipping.
  - If relu is set, negative results are forced to 0; o_sat keeps the pre-ReLU value.
- o_pixel_bus and o_sat_bus hold their values until the next result. No backpressure: the consumer must accept every o_valid pulse.
- Windows run back-to-back with no bubble. A first-tagged beat reloads the accumulator in the same cycle the previous window's last beat reaches S3.
- i_valid=0 gaps inside a window are allowed; the counter and accumulators hold.
- i_clear=1:
  - Tap counter goes to 0, and the S1/S2 valid tags are cleared, so in-flight beats never produce o_valid.
  - A result already in S3 still completes its pulse.
  - i_clear together with i_valid: clear wins and the beat is dropped.
  - The next accepted beat is tagged first.
- KERNEL_TAPS=1: every beat is both first and last.

## Timing
- Reset (rst=1 at an edge): o_valid=0, o_pixel_bus=0, o_sat_bus=0, o_tap_cnt=0, all pipeline tags 0, accumulators 0. rst takes priority over i_clear and i_valid.
- Reset mid-window drops the partial window and in-flight beats.
- Latency: a last beat presented in cycle n gives o_valid=1 in cycle n+3 only. o_pixel_bus is valid from cycle n+3 and holds after.
- o_tap_cnt updates at the edge that accepts a beat; it reads 0 in the cycle after the last beat.
- Peak throughput: one window per KERNEL_TAPS cycles.

## Test plan
1. Reset, then 9 beats with every pixel = 0x0100 (1.0), weight = 0x0100, relu=0 → single o_valid 3 cycles after beat 9; every lane = 0x0900; o_sat_bus=0; o_tap_cnt 1..8 then 0.
2. Lane ordering: lane k pixel = (k+1)<<8, weight = 0x0100, 9 beats → lane 0 (MSB slice) = 0x0900, lane 5 (LSB slice) = 0x3600.
3. Saturation/ReLU: pixel = 0x7FFF, weight = 0x7FFF, 9 beats → all lanes 0x7FFF with o_sat all 1s. Repeat with weight = 0x8000 and relu=0 → 0x8000, sat=1; with relu=1 → 0x0000, sat=1.
4. Back-to-back: 27 continuous beats with pixel = 0x0100 and weight 0x0100, 0x0200, 0x0300 per window → o_valid in cycles 12, 21, 30 (first beat in cycle 1) with lane values 0x0900, 0x1200, 0x1B00.
5. Gaps and clear: 5 beats, i_clear=1 for 1 cycle, then 9 beats of value 1.0×1.0 with idle cycles between them → exactly one o_valid, lane value 0x0900; no pulse from the aborted window.
6. Mid-window rst=1 after 4 beats, then 9 beats → outputs 0 during reset; one result = 0x0900. Also rerun with ARRAY_SIZE=1 and KERNEL_TAPS=1: each beat gives pixel*weight>>>8 three cycles later.
